// File: rtl/hazard_detection_unit.sv
`default_nettype none
// ============================================================================
// hazard_detection_unit : load-use stall detector beside the ID stage, with
// registered stall statistics.                         Revision: 1.0
// ============================================================================
module hazard_detection_unit #(
  parameter int REG_W       = 5,
  parameter int CNT_W       = 32,
  parameter bit ZERO_EXEMPT = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ID_EX_MemRead,
  input  logic [REG_W-1:0] ID_EX_RegRt,
  input  logic [REG_W-1:0] IF_ID_RegRs,
  input  logic [REG_W-1:0] IF_ID_RegRt,
  output logic             Mux_Select_Stall,
  output logic             PCWrite,
  output logic             IF_ID_Write,
  output logic [CNT_W-1:0] stall_count,
  output logic             stall_last
);

  localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};

  logic             w_match;
  logic             w_zero_dest;
  logic             w_hazard;
  logic [CNT_W-1:0] stall_count_d;
  logic [CNT_W-1:0] stall_count_q;
  logic             stall_last_d;
  logic             stall_last_q;

  // A match on rs, rt or both is the same single stall.
  always_comb begin
    w_match     = (ID_EX_RegRt == IF_ID_RegRs) || (ID_EX_RegRt == IF_ID_RegRt);
    w_zero_dest = ZERO_EXEMPT && (ID_EX_RegRt == '0);
    w_hazard    = ID_EX_MemRead && w_match && !w_zero_dest;
  end

  assign Mux_Select_Stall = w_hazard;
  assign PCWrite          = ~w_hazard;
  assign IF_ID_Write      = ~w_hazard;

  // Counter saturates at all-ones so long runs never wrap back to small values.
  always_comb begin
    stall_count_d = stall_count_q;
    stall_last_d  = w_hazard;
    if (w_hazard && (stall_count_q != C_CNT_MAX)) begin
      stall_count_d = stall_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_count_q <= '0;
      stall_last_q  <= 1'b0;
    end else begin
      stall_count_q <= stall_count_d;
      stall_last_q  <= stall_last_d;
    end
  end

  assign stall_count = stall_count_q;
  assign stall_last  = stall_last_q;

endmodule
`default_nettype wire

// File: tb/tb_hazard_detection_unit.sv
`default_nettype none
// ============================================================================
// tb_hazard_detection_unit : self-checking bench for hazard_detection_unit
// (default, ZERO_EXEMPT=0 and CNT_W=4 instances).      Revision: 1.0
// ============================================================================
module tb_hazard_detection_unit;

  logic       clk;
  logic       rst;
  logic       mr;
  logic [4:0] ex_rt;
  logic [4:0] id_rs;
  logic [4:0] id_rt;

  logic        mux_a, pcw_a, ifw_a, last_a;
  logic [31:0] cnt_a;
  logic        mux_z, pcw_z, ifw_z, last_z;
  logic [31:0] cnt_z;
  logic        mux_c, pcw_c, ifw_c, last_c;
  logic [3:0]  cnt_c;

  hazard_detection_unit #(.REG_W(5), .CNT_W(32), .ZERO_EXEMPT(1'b1)) u_dut (
    .clk(clk), .rst(rst), .ID_EX_MemRead(mr), .ID_EX_RegRt(ex_rt),
    .IF_ID_RegRs(id_rs), .IF_ID_RegRt(id_rt), .Mux_Select_Stall(mux_a),
    .PCWrite(pcw_a), .IF_ID_Write(ifw_a), .stall_count(cnt_a), .stall_last(last_a));

  hazard_detection_unit #(.REG_W(5), .CNT_W(32), .ZERO_EXEMPT(1'b0)) u_dut_z0 (
    .clk(clk), .rst(rst), .ID_EX_MemRead(mr), .ID_EX_RegRt(ex_rt),
    .IF_ID_RegRs(id_rs), .IF_ID_RegRt(id_rt), .Mux_Select_Stall(mux_z),
    .PCWrite(pcw_z), .IF_ID_Write(ifw_z), .stall_count(cnt_z), .stall_last(last_z));

  hazard_detection_unit #(.REG_W(5), .CNT_W(4), .ZERO_EXEMPT(1'b1)) u_dut_c4 (
    .clk(clk), .rst(rst), .ID_EX_MemRead(mr), .ID_EX_RegRt(ex_rt),
    .IF_ID_RegRs(id_rs), .IF_ID_RegRt(id_rt), .Mux_Select_Stall(mux_c),
    .PCWrite(pcw_c), .IF_ID_Write(ifw_c), .stall_count(cnt_c), .stall_last(last_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       m;
    logic [4:0] e;
    logic [4:0] s;
    logic [4:0] t;
    logic       hz;
    logic       hz_z0;
  } vec_t;

  typedef struct {
    logic hz;
    logic hz_z0;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_err    = 0;
  logic        cur_hz, cur_hz_z0;
  logic [31:0] m_cnt_a, m_cnt_z;
  logic [3:0]  m_cnt_c;
  logic        m_last_a, m_last_z;
  vec_t        vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic ref_hz(input logic m, input logic [4:0] e, input logic [4:0] s,
                                  input logic [4:0] t, input bit ze);
    return m && ((e == s) || (e == t)) && !(ze && (e == 5'd0));
  endfunction

  task automatic check_comb();
    exp_t x;
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
      return;
    end
    x = exp_q.pop_front();
    check("mux",        {31'd0, mux_a}, {31'd0, x.hz});
    check("pcwrite",    {31'd0, pcw_a}, {31'd0, ~x.hz});
    check("ifid_write", {31'd0, ifw_a}, {31'd0, ~x.hz});
    check("mux_z0",     {31'd0, mux_z}, {31'd0, x.hz_z0});
    check("pcwrite_z0", {31'd0, pcw_z}, {31'd0, ~x.hz_z0});
    check("mux_c4",     {31'd0, mux_c}, {31'd0, x.hz});
    check("ifid_c4",    {31'd0, ifw_c}, {31'd0, ~x.hz});
  endtask

  task automatic drive(input logic m, input logic [4:0] e, input logic [4:0] s,
                       input logic [4:0] t, input logic hz, input logic hz_z0);
    exp_t x;
    mr = m; ex_rt = e; id_rs = s; id_rt = t;
    x.hz = hz; x.hz_z0 = hz_z0;
    exp_q.push_back(x);
    cur_hz = hz; cur_hz_z0 = hz_z0;
    #1;
    check_comb();
  endtask

  task automatic check_regs();
    check("count",      cnt_a,           m_cnt_a);
    check("last",       {31'd0, last_a}, {31'd0, m_last_a});
    check("count_z0",   cnt_z,           m_cnt_z);
    check("last_z0",    {31'd0, last_z}, {31'd0, m_last_z});
    check("count_c4",   {28'd0, cnt_c},  {28'd0, m_cnt_c});
  endtask

  task automatic zero_model();
    m_cnt_a = '0; m_cnt_z = '0; m_cnt_c = '0; m_last_a = 1'b0; m_last_z = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) begin
      zero_model();
    end else begin
      if (cur_hz) m_cnt_a = m_cnt_a + 1;
      if (cur_hz_z0) m_cnt_z = m_cnt_z + 1;
      if (cur_hz && (m_cnt_c != 4'hF)) m_cnt_c = m_cnt_c + 1'b1;
      m_last_a = cur_hz;
      m_last_z = cur_hz_z0;
    end
    #1;
    check_regs();
  endtask

  initial begin
    vecs[0] = '{1'b1, 5'd5,  5'd5,  5'd7,  1'b1, 1'b1};
    vecs[1] = '{1'b1, 5'd9,  5'd3,  5'd9,  1'b1, 1'b1};
    vecs[2] = '{1'b1, 5'd10, 5'd3,  5'd9,  1'b0, 1'b0};
    vecs[3] = '{1'b0, 5'd12, 5'd12, 5'd12, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 5'd0,  5'd0,  5'd4,  1'b0, 1'b1};
    vecs[5] = '{1'b1, 5'd0,  5'd3,  5'd0,  1'b0, 1'b1};
    vecs[6] = '{1'b1, 5'd7,  5'd7,  5'd7,  1'b1, 1'b1};
    vecs[7] = '{1'b1, 5'd31, 5'd31, 5'd2,  1'b1, 1'b1};
    vecs[8] = '{1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0};
    vecs[9] = '{1'b1, 5'd6,  5'd1,  5'd2,  1'b0, 1'b0};

    rst = 1'b1; mr = 1'b0; ex_rt = '0; id_rs = 5'd1; id_rt = 5'd2;
    cur_hz = 1'b0; cur_hz_z0 = 1'b0;
    zero_model();
    repeat (2) @(posedge clk);
    #1;
    check_regs();
    rst = 1'b0;

    // Table-driven vectors, two edges each so counting is seen per edge.
    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].m, vecs[i].e, vecs[i].s, vecs[i].t, vecs[i].hz, vecs[i].hz_z0);
      tick();
      tick();
    end

    // Hazard held 4 cycles, asynchronous reset pulsed mid-stall.
    drive(1'b1, 5'd5, 5'd5, 5'd7, 1'b1, 1'b1);
    repeat (4) tick();
    #3;
    rst = 1'b1;
    #1;
    zero_model();
    check_regs();
    drive(1'b1, 5'd5, 5'd5, 5'd7, 1'b1, 1'b1);
    tick();
    rst = 1'b0;
    tick();
    check("count_after_rst", cnt_a, 32'd1);
    check("last_after_rst", {31'd0, last_a}, 32'd1);

    // Long hold to drive the 4-bit counter into saturation.
    repeat (18) tick();
    check("c4_saturated", {28'd0, cnt_c}, 32'd15);

    // Random traffic, register fields kept narrow to make matches common.
    rst = 1'b1;
    #1;
    zero_model();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      logic       m;
      logic [4:0] e, s, t;
      m = 1'($urandom_range(0, 1));
      e = 5'($urandom_range(0, 3));
      s = 5'($urandom_range(0, 3));
      t = 5'($urandom_range(0, 3));
      drive(m, e, s, t, ref_hz(m, e, s, t, 1'b1), ref_hz(m, e, s, t, 1'b0));
      tick();
    end
    check("scoreboard_drained", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
